exrom_burst: RTL and testbench
==============================

// Module: exrom_burst
// PURPOSE
//   Parametrised external-ROM model, successor to the fixed 16x128 single-read ROM.
//   Serves burst reads (1..2**BL_W beats) with a programmable access latency.
//   Address auto-increments with wrap-around; consumer back-pressure via i_STALL.
//   Adds a side write port so the bench or boot logic can preload contents.
//   Sits between the TPU/RISC fetch logic and the off-chip memory.
// PARAMETERS
//   DATA_W   16  data word width
//   ADDR_W   7   address width; DEPTH = 2**ADDR_W words
//   LATENCY  5   cycles from request capture to first beat registered (>=1)
//   BL_W     3   burst-length field width; burst = i_BLEN+1 beats (1..8 at default)
// PORTS
//   i_SCLK     in   1       clock, all logic on rising edge
//   i_RESET    in   1       synchronous reset, active-high
//   i_RD_RQST  in   1       read request, level, sampled only while o_BUSY=0
//   i_ADDR     in   ADDR_W  start address, captured with request
//   i_BLEN     in   BL_W    beats-1, captured with request
//   i_STALL    in   1       consumer not ready; holds current beat
//   i_WR_EN    in   1       preload write strobe
//   i_WR_ADDR  in   ADDR_W  preload write address
//   i_WR_DATA  in   DATA_W  preload write data
//   o_DO       out  DATA_W  read data; 0 whenever o_VALID=0
//   o_VALID    out  1       o_DO holds a beat
//   o_LAST     out  1       current beat is final beat of burst (only with o_VALID)
//   o_BUSY     out  1       burst in progress; new requests ignored
// BEHAVIOUR
//   Reset: o_DO=0, o_VALID=0, o_LAST=0, o_BUSY=0, FSM=IDLE, counters=0.
//   Memory array is never cleared by reset.
//   FSM states: IDLE, WAIT, BURST.
//   - IDLE: edge with i_RD_RQST=1 captures i_ADDR, i_BLEN.
//     Latency counter is loaded with LATENCY-1 and the FSM goes to WAIT; o_BUSY=1 from that edge.
//   - WAIT: counter decrements each edge. At the edge where it is 0:
//     o_DO=mem[addr], o_VALID=1, o_LAST=(BLEN==0), FSM goes to BURST.
//     First beat is therefore visible LATENCY edges after the capture edge.
//   - BURST: a beat is consumed on an edge with o_VALID=1 and i_STALL=0.
//     On consume, if more beats remain: addr=addr+1 (mod 2**ADDR_W), the next word is registered
//     the same edge (back-to-back, no bubble), and o_LAST is set on the final beat.
//     On consume of the last beat: o_VALID=0, o_DO=0, o_LAST=0, o_BUSY=0, FSM goes to IDLE.
//   - i_STALL=1: o_DO, o_VALID, o_LAST and addr are held unchanged. In WAIT, stall is ignored.
//   - Requests: at least one IDLE cycle separates bursts.
//     A held-high i_RD_RQST starts a new burst on the first IDLE edge.
//     i_RD_RQST while o_BUSY=1 is dropped, not queued.
//   - Write port: active any cycle, memory updated at the edge.
//     A beat registered on the same edge as a write to its address returns the OLD word.
//     The new word is visible from the next edge.
//     A held (stalled) beat is not refreshed by a later write.
//   - Address wrap: the word after 2**ADDR_W-1 is address 0, within one burst.
//   - Reset mid-burst: the next edge forces the reset values and drops the burst; memory is kept.
// TESTING
//   1 preload mem[5]=16'hA5A5, req addr=5 blen=0 LAT=5
//     -> o_VALID 1 cycle, 5 edges after capture, o_DO=A5A5, o_LAST=1; o_BUSY low next edge.
//   2 mem[i]=i, req addr=126 blen=3 (ADDR_W=7)
//     -> beats 126,127,0,1 back-to-back, o_LAST only on beat value 1.
//   3 same burst addr=0 blen=3, i_STALL=1 for 3 cycles on beat 1
//     -> o_DO holds 1 for 4 cycles; sequence 0,1,2,3 unchanged.
//   4 i_RD_RQST held high, blen=1
//     -> bursts repeat with exactly one IDLE cycle between; a second request mid-burst is ignored.
//   5 write mem[9]=BEEF on the same edge beat addr 9 is registered
//     -> beat shows old value; a following burst at 9 returns BEEF.
//   6 i_RESET for 1 cycle mid-burst
//     -> next edge o_VALID=0, o_DO=0, o_BUSY=0; new request afterwards reads preloaded data intact.

Source files
------------

// File: rtl/exrom_burst.sv
// -----------------------------------------------------------------------------
// exrom_burst
//   Parametrised external-ROM model serving burst reads with a programmable
//   access latency. The address auto-increments and wraps at 2**ADDR_W.
//   The consumer applies back-pressure with i_STALL.
//   A side write port lets boot logic or a bench preload the contents.
//
// Ports
//   i_SCLK     clock, all logic on the rising edge
//   i_RESET    synchronous reset, active-high (memory contents are kept)
//   i_RD_RQST  read request (level), sampled only while idle
//   i_ADDR     burst start address, captured with the request
//   i_BLEN     burst length minus one, captured with the request
//   i_STALL    consumer not ready; the current beat is held
//   i_WR_EN    preload write strobe
//   i_WR_ADDR  preload write address
//   i_WR_DATA  preload write data
//   o_DO       read data, zero whenever o_VALID is low
//   o_VALID    o_DO holds a beat
//   o_LAST     the current beat is the final beat of the burst
//   o_BUSY     a burst is in progress; new requests are ignored
// -----------------------------------------------------------------------------
module exrom_burst #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 7,
    parameter int LATENCY = 5,
    parameter int BL_W    = 3
) (
    input  logic              i_SCLK,
    input  logic              i_RESET,
    input  logic              i_RD_RQST,
    input  logic [ADDR_W-1:0] i_ADDR,
    input  logic [BL_W-1:0]   i_BLEN,
    input  logic              i_STALL,
    input  logic              i_WR_EN,
    input  logic [ADDR_W-1:0] i_WR_ADDR,
    input  logic [DATA_W-1:0] i_WR_DATA,
    output logic [DATA_W-1:0] o_DO,
    output logic              o_VALID,
    output logic              o_LAST,
    output logic              o_BUSY
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int LAT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [DATA_W-1:0] mem_r [0:DEPTH-1];
    logic [1:0]        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [BL_W-1:0]   rem_r;     // beats still to come after the current one
    logic [LAT_W-1:0]  lat_r;
    logic [ADDR_W-1:0] addr_inc_s;

    // Next burst address; the natural ADDR_W-bit overflow gives the wrap to 0.
    always_comb begin
        addr_inc_s = addr_r + ADDR_W'(1);
    end

    // Preload write port. Reads in the FSM below sample the array before this
    // update lands, so a beat registered on the same edge returns the old word.
    always_ff @(posedge i_SCLK) begin
        if (i_WR_EN) begin
            mem_r[i_WR_ADDR] <= i_WR_DATA;
        end else begin
            mem_r[i_WR_ADDR] <= mem_r[i_WR_ADDR];
        end
    end

    // Burst controller: request capture, latency countdown, beat delivery.
    always_ff @(posedge i_SCLK) begin
        if (i_RESET) begin
            state_r <= ST_IDLE;
            addr_r  <= {ADDR_W{1'b0}};
            rem_r   <= {BL_W{1'b0}};
            lat_r   <= {LAT_W{1'b0}};
            o_DO    <= {DATA_W{1'b0}};
            o_VALID <= 1'b0;
            o_LAST  <= 1'b0;
            o_BUSY  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_RD_RQST) begin
                        addr_r  <= i_ADDR;
                        rem_r   <= i_BLEN;
                        lat_r   <= LAT_W'(LATENCY - 1);
                        o_BUSY  <= 1'b1;
                        state_r <= ST_WAIT;
                    end else begin
                        o_BUSY  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    // Stall is deliberately ignored here: the countdown always runs.
                    if (lat_r == {LAT_W{1'b0}}) begin
                        o_DO    <= mem_r[addr_r];
                        o_VALID <= 1'b1;
                        o_LAST  <= (rem_r == {BL_W{1'b0}});
                        state_r <= ST_BURST;
                    end else begin
                        lat_r   <= lat_r - LAT_W'(1);
                    end
                end
                ST_BURST: begin
                    if (o_VALID && !i_STALL) begin
                        if (rem_r != {BL_W{1'b0}}) begin
                            // Register the next word on the consume edge: no bubble.
                            addr_r  <= addr_inc_s;
                            o_DO    <= mem_r[addr_inc_s];
                            rem_r   <= rem_r - BL_W'(1);
                            o_LAST  <= (rem_r == BL_W'(1));
                        end else begin
                            o_DO    <= {DATA_W{1'b0}};
                            o_VALID <= 1'b0;
                            o_LAST  <= 1'b0;
                            o_BUSY  <= 1'b0;
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        // Stalled: hold beat and address; a later write does not refresh it.
                        o_DO    <= o_DO;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_DO    <= {DATA_W{1'b0}};
                    o_VALID <= 1'b0;
                    o_LAST  <= 1'b0;
                    o_BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exrom_burst.sv
module tb_exrom_burst;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 7;
    localparam int LATENCY = 5;
    localparam int BL_W    = 3;

    logic              clk;
    logic              rst;
    logic              rd_rqst;
    logic [ADDR_W-1:0] addr;
    logic [BL_W-1:0]   blen;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    exrom_burst #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LATENCY(LATENCY),
        .BL_W   (BL_W)
    ) dut (
        .i_SCLK   (clk),
        .i_RESET  (rst),
        .i_RD_RQST(rd_rqst),
        .i_ADDR   (addr),
        .i_BLEN   (blen),
        .i_STALL  (stall),
        .i_WR_EN  (wr_en),
        .i_WR_ADDR(wr_addr),
        .i_WR_DATA(wr_data),
        .o_DO     (dout),
        .o_VALID  (valid),
        .o_LAST   (last),
        .o_BUSY   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until a beat appears or the budget runs out; returns edges taken.
    task automatic run_to_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid && n < 20);
    endtask

    // Issue a one-cycle request; returns after the capture edge.
    task automatic request(input logic [ADDR_W-1:0] a, input logic [BL_W-1:0] b);
        rd_rqst = 1'b1;
        addr    = a;
        blen    = b;
        tick();
        rd_rqst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({dout, valid, last, busy} !== {16'h0000, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset: do=%h v=%b l=%b b=%b, want 0000 0 0 0", dout, valid, last, busy);
        end
    endtask

    task automatic test_single();
        int n;
        wr_en = 1'b1; wr_addr = 7'd5; wr_data = 16'hA5A5;
        tick();
        wr_en = 1'b0;
        request(7'd5, 3'd0);
        checks++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL single_capture: busy=%b valid=%b, want 1 0", busy, valid);
        end
        run_to_valid(n);
        checks++;
        if (n !== LATENCY) begin
            errors++;
            $display("FAIL single_latency: edges=%0d, want %0d", n, LATENCY);
        end
        checks++;
        if ({valid, dout, last} !== {1'b1, 16'hA5A5, 1'b1}) begin
            errors++;
            $display("FAIL single_beat: v=%b do=%h l=%b, want 1 a5a5 1", valid, dout, last);
        end
        tick();
        checks++;
        if ({valid, dout, last, busy} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL single_end: v=%b do=%h l=%b b=%b, want 0 0000 0 0", valid, dout, last, busy);
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] exp_do [4];
        int n;
        exp_do[0] = 16'd126; exp_do[1] = 16'd127; exp_do[2] = 16'd0; exp_do[3] = 16'd1;
        for (int i = 0; i < 128; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_data = DATA_W'(i);
            tick();
        end
        wr_en = 1'b0;
        request(7'd126, 3'd3);
        run_to_valid(n);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({valid, dout, last} !== {1'b1, exp_do[i], (i == 3)}) begin
                errors++;
                $display("FAIL wrap_beat%0d: v=%b do=%0d l=%b, want 1 %0d %b",
                         i, valid, dout, last, exp_do[i], (i == 3));
            end
            tick();
        end
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: v=%b b=%b, want 0 0", valid, busy);
        end
    endtask

    task automatic test_stall();
        logic [DATA_W-1:0] exp_do [7];
        int n;
        // beat 1 is held for four samples (three stalled edges)
        exp_do[0] = 16'd0; exp_do[1] = 16'd1; exp_do[2] = 16'd1; exp_do[3] = 16'd1;
        exp_do[4] = 16'd1; exp_do[5] = 16'd2; exp_do[6] = 16'd3;
        request(7'd0, 3'd3);
        run_to_valid(n);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if ({valid, dout, last} !== {1'b1, exp_do[i], (i == 6)}) begin
                errors++;
                $display("FAIL stall_sample%0d: v=%b do=%0d l=%b, want 1 %0d %b",
                         i, valid, dout, last, exp_do[i], (i == 6));
            end
            stall = (i >= 1 && i <= 3);
            tick();
        end
        stall = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: v=%b b=%b, want 0 0", valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        rd_rqst = 1'b1; addr = 7'd10; blen = 3'd1;
        tick();
        addr = 7'd50;   // changed mid-burst: must not restart or redirect the burst
        run_to_valid(n);
        checks++;
        if ({valid, dout, last} !== {1'b1, 16'd10, 1'b0}) begin
            errors++;
            $display("FAIL b2b_first0: v=%b do=%0d l=%b, want 1 10 0", valid, dout, last);
        end
        tick();
        checks++;
        if ({valid, dout, last} !== {1'b1, 16'd11, 1'b1}) begin
            errors++;
            $display("FAIL b2b_first1: v=%b do=%0d l=%b, want 1 11 1", valid, dout, last);
        end
        addr = 7'd20;
        tick();
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b valid=%b, want 0 0", busy, valid);
        end
        tick();
        rd_rqst = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_restart: busy=%b, want 1", busy);
        end
        run_to_valid(n);
        checks++;
        if (n !== LATENCY || dout !== 16'd20) begin
            errors++;
            $display("FAIL b2b_second0: edges=%0d do=%0d, want %0d 20", n, dout, LATENCY);
        end
        tick();
        checks++;
        if ({dout, last} !== {16'd21, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second1: do=%0d l=%b, want 21 1", dout, last);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b, want 0", busy);
        end
    endtask

    task automatic test_write_collision();
        int n;
        request(7'd8, 3'd1);
        run_to_valid(n);
        wr_en = 1'b1; wr_addr = 7'd9; wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        checks++;
        if (dout !== 16'd9) begin
            errors++;
            $display("FAIL collide_old: do=%h, want 0009", dout);
        end
        tick();
        request(7'd9, 3'd0);
        run_to_valid(n);
        checks++;
        if (dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL collide_new: do=%h, want beef", dout);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int n;
        request(7'd30, 3'd7);
        run_to_valid(n);
        tick();
        tick();
        checks++;
        if (dout !== 16'd32) begin
            errors++;
            $display("FAIL midrst_pre: do=%0d, want 32", dout);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({valid, dout, last, busy} !== {1'b0, 16'h0000, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL midrst_clear: v=%b do=%h l=%b b=%b, want 0 0000 0 0", valid, dout, last, busy);
        end
        request(7'd9, 3'd1);
        run_to_valid(n);
        checks++;
        if (n !== LATENCY || dout !== 16'hBEEF) begin
            errors++;
            $display("FAIL midrst_mem0: edges=%0d do=%h, want %0d beef", n, dout, LATENCY);
        end
        tick();
        checks++;
        if ({dout, last} !== {16'd10, 1'b1}) begin
            errors++;
            $display("FAIL midrst_mem1: do=%0d l=%b, want 10 1", dout, last);
        end
        tick();
    endtask

    initial begin
        rst = 1'b0; rd_rqst = 1'b0; addr = '0; blen = '0; stall = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        test_reset();
        test_single();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_write_collision();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
